// File: rtl/arm7_pkg.sv
// Shared ARM7 definitions: mode codes, CPSR bit positions, CPSR mode-bit
// encodings, exception vectors, reset CPSR and the logical->physical
// register index map used by the banked register file.
package arm7_pkg;

  typedef enum logic [2:0] {
    MODE_USR = 3'd0,
    MODE_SYS = 3'd1,
    MODE_FIQ = 3'd2,
    MODE_IRQ = 3'd3,
    MODE_SVC = 3'd4,
    MODE_ABT = 3'd5,
    MODE_UND = 3'd6
  } mode_e;

  // CPSR bit positions
  localparam int unsigned CPSR_N = 31;
  localparam int unsigned CPSR_Z = 30;
  localparam int unsigned CPSR_C = 29;
  localparam int unsigned CPSR_V = 28;
  localparam int unsigned CPSR_I = 7;
  localparam int unsigned CPSR_F = 6;
  localparam int unsigned CPSR_T = 5;
  localparam int unsigned CPSR_M_HI = 4;
  localparam int unsigned CPSR_M_LO = 0;

  // CPSR[4:0] encodings
  localparam logic [4:0] MBITS_USR = 5'b10000;
  localparam logic [4:0] MBITS_SYS = 5'b11111;
  localparam logic [4:0] MBITS_FIQ = 5'b10001;
  localparam logic [4:0] MBITS_IRQ = 5'b10010;
  localparam logic [4:0] MBITS_SVC = 5'b10011;
  localparam logic [4:0] MBITS_ABT = 5'b10111;
  localparam logic [4:0] MBITS_UND = 5'b11011;

  // Exception vectors
  localparam logic [31:0] VEC_UND = 32'h0000_0004;
  localparam logic [31:0] VEC_SVC = 32'h0000_0008;
  localparam logic [31:0] VEC_ABT = 32'h0000_0010;
  localparam logic [31:0] VEC_IRQ = 32'h0000_0018;
  localparam logic [31:0] VEC_FIQ = 32'h0000_001C;

  localparam logic [31:0] RESET_CPSR_DEFAULT = 32'h0000_00D3;

  // r0-r15 common, r8-r14 FIQ, then r13/r14 pairs for IRQ, SVC, ABT, UND
  localparam int unsigned NUM_PHYS = 31;
  localparam int unsigned NUM_SPSR = 5;

  function automatic mode_e decode_mode(input logic [4:0] mbits);
    case (mbits)
      MBITS_SYS: return MODE_SYS;
      MBITS_FIQ: return MODE_FIQ;
      MBITS_IRQ: return MODE_IRQ;
      MBITS_SVC: return MODE_SVC;
      MBITS_ABT: return MODE_ABT;
      MBITS_UND: return MODE_UND;
      default:   return MODE_USR;
    endcase
  endfunction

  function automatic logic [4:0] mode_bits(input mode_e m);
    case (m)
      MODE_SYS: return MBITS_SYS;
      MODE_FIQ: return MBITS_FIQ;
      MODE_IRQ: return MBITS_IRQ;
      MODE_SVC: return MBITS_SVC;
      MODE_ABT: return MBITS_ABT;
      MODE_UND: return MBITS_UND;
      default:  return MBITS_USR;
    endcase
  endfunction

  function automatic logic [31:0] exc_vector(input mode_e m);
    case (m)
      MODE_FIQ: return VEC_FIQ;
      MODE_IRQ: return VEC_IRQ;
      MODE_ABT: return VEC_ABT;
      MODE_UND: return VEC_UND;
      default:  return VEC_SVC;
    endcase
  endfunction

  // Offsets fold the logical register number into the bank base:
  // FIQ r8 -> 16, IRQ r13 -> 23, SVC r13 -> 25, ABT r13 -> 27, UND r13 -> 29.
  function automatic logic [4:0] phys_index(input logic [3:0] r, input mode_e m);
    logic [4:0] rx;
    rx = {1'b0, r};
    if (r == 4'd15 || r < 4'd8) return rx;
    if (m == MODE_FIQ) return rx + 5'd8;
    if (r < 4'd13) return rx;
    case (m)
      MODE_IRQ: return rx + 5'd10;
      MODE_SVC: return rx + 5'd12;
      MODE_ABT: return rx + 5'd14;
      MODE_UND: return rx + 5'd16;
      default:  return rx;
    endcase
  endfunction

endpackage

// File: rtl/arm7_mode_map.sv
// Combinational mode decode and register banking map.
//   cpsr_mode  in  5  CPSR[4:0]
//   reg_idx    in  4  logical register r0..r15
//   mode_code  out 3  decoded mode code (unknown encodings -> USR)
//   has_spsr   out 1  mode owns an SPSR (not USR/SYS)
//   phys_idx   out 5  physical register index 0..30
module arm7_mode_map
  import arm7_pkg::*;
(
  input  logic [4:0] cpsr_mode,
  input  logic [3:0] reg_idx,
  output logic [2:0] mode_code,
  output logic       has_spsr,
  output logic [4:0] phys_idx
);

  mode_e mode;

  always_comb begin
    mode      = decode_mode(cpsr_mode);
    mode_code = mode;
    has_spsr  = (mode != MODE_USR) && (mode != MODE_SYS);
    phys_idx  = phys_index(reg_idx, mode);
  end

endmodule

// File: rtl/arm7_banked_regfile.sv
// ARM7 banked register file with CPSR and five SPSRs.
//   clk, rst_n                         clock, async active-low reset
//   read_en/read_reg/read_value        registered GPR read (1 edge)
//   write_en/write_reg/write_value     GPR write, banked by pre-edge mode
//   write_restore_from_SPSR            with r15 write: CPSR <= SPSR[mode]
//   mode_read_en/mode_read_value       registered {29'b0, mode_code}
//   cpsr_read_en/cpsr_read_value       registered CPSR
//   cpsr_write_en/cpsr_write_value     full-word CPSR write
//   exc_en/exc_mode/exc_return         exception entry (modes 2..6)
// Same-edge priority: exception > restore > CPSR write.
module arm7_banked_regfile
  import arm7_pkg::*;
#(
  parameter logic [31:0] RESET_CPSR = RESET_CPSR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_en,
  input  logic [3:0]  read_reg,
  output logic [31:0] read_value,
  input  logic        write_en,
  input  logic [3:0]  write_reg,
  input  logic [31:0] write_value,
  input  logic        write_restore_from_SPSR,
  input  logic        mode_read_en,
  output logic [31:0] mode_read_value,
  input  logic        cpsr_read_en,
  output logic [31:0] cpsr_read_value,
  input  logic        cpsr_write_en,
  input  logic [31:0] cpsr_write_value,
  input  logic        exc_en,
  input  logic [2:0]  exc_mode,
  input  logic [31:0] exc_return
);

  logic [31:0] gpr  [NUM_PHYS];
  logic [31:0] spsr [NUM_SPSR];
  logic [31:0] cpsr;

  logic [2:0]  rd_mode_code;
  logic [4:0]  rd_phys;
  logic [2:0]  wr_mode_code;
  logic        wr_has_spsr;
  logic [4:0]  wr_phys;

  arm7_mode_map u_rd_map (
    .cpsr_mode (cpsr[CPSR_M_HI:CPSR_M_LO]),
    .reg_idx   (read_reg),
    .mode_code (rd_mode_code),
    .has_spsr  (),
    .phys_idx  (rd_phys)
  );

  arm7_mode_map u_wr_map (
    .cpsr_mode (cpsr[CPSR_M_HI:CPSR_M_LO]),
    .reg_idx   (write_reg),
    .mode_code (wr_mode_code),
    .has_spsr  (wr_has_spsr),
    .phys_idx  (wr_phys)
  );

  logic        exc_valid;
  logic        restore;
  mode_e       exc_m;
  logic [2:0]  exc_spsr_idx;
  logic [2:0]  cur_spsr_idx;
  logic [4:0]  exc_r14_phys;
  logic [31:0] exc_cpsr;

  always_comb begin
    exc_valid    = exc_en && (exc_mode >= 3'd2) && (exc_mode <= 3'd6);
    exc_m        = mode_e'(exc_mode);
    restore      = write_en && (write_reg == 4'd15) && write_restore_from_SPSR && wr_has_spsr;
    // SPSR array is indexed by mode_code - FIQ (FIQ..UND -> 0..4)
    exc_spsr_idx = exc_mode - 3'd2;
    cur_spsr_idx = wr_mode_code - 3'd2;
    exc_r14_phys = phys_index(4'd14, exc_m);
    exc_cpsr     = cpsr;
    exc_cpsr[CPSR_M_HI:CPSR_M_LO] = mode_bits(exc_m);
    exc_cpsr[CPSR_I] = 1'b1;
    if (exc_m == MODE_FIQ) exc_cpsr[CPSR_F] = 1'b1;
    exc_cpsr[CPSR_T] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_PHYS; i++) gpr[i] <= '0;
      for (int unsigned i = 0; i < NUM_SPSR; i++) spsr[i] <= '0;
      cpsr            <= RESET_CPSR;
      read_value      <= '0;
      mode_read_value <= '0;
      cpsr_read_value <= '0;
    end else begin
      if (read_en)      read_value      <= gpr[rd_phys];
      if (mode_read_en) mode_read_value <= {29'b0, rd_mode_code};
      if (cpsr_read_en) cpsr_read_value <= cpsr;

      if (exc_valid) begin
        spsr[exc_spsr_idx] <= cpsr;
        gpr[exc_r14_phys]  <= exc_return;
        gpr[15]            <= exc_vector(exc_m);
        cpsr               <= exc_cpsr;
      end else begin
        if (write_en) gpr[wr_phys] <= write_value;
        if (restore) cpsr <= spsr[cur_spsr_idx];
        else if (cpsr_write_en) cpsr <= cpsr_write_value;
      end
    end
  end

endmodule

// File: tb/tb_arm7_banked_regfile.sv
module tb_arm7_banked_regfile;

  logic        clk;
  logic        rst_n;
  logic        read_en;
  logic [3:0]  read_reg;
  logic [31:0] read_value;
  logic        write_en;
  logic [3:0]  write_reg;
  logic [31:0] write_value;
  logic        write_restore_from_SPSR;
  logic        mode_read_en;
  logic [31:0] mode_read_value;
  logic        cpsr_read_en;
  logic [31:0] cpsr_read_value;
  logic        cpsr_write_en;
  logic [31:0] cpsr_write_value;
  logic        exc_en;
  logic [2:0]  exc_mode;
  logic [31:0] exc_return;

  int errors = 0;
  int checks = 0;

  arm7_banked_regfile #(.RESET_CPSR(32'h0000_00D3)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .read_en                 (read_en),
    .read_reg                (read_reg),
    .read_value              (read_value),
    .write_en                (write_en),
    .write_reg               (write_reg),
    .write_value             (write_value),
    .write_restore_from_SPSR (write_restore_from_SPSR),
    .mode_read_en            (mode_read_en),
    .mode_read_value         (mode_read_value),
    .cpsr_read_en            (cpsr_read_en),
    .cpsr_read_value         (cpsr_read_value),
    .cpsr_write_en           (cpsr_write_en),
    .cpsr_write_value        (cpsr_write_value),
    .exc_en                  (exc_en),
    .exc_mode                (exc_mode),
    .exc_return              (exc_return)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    read_en = 0; read_reg = 0; write_en = 0; write_reg = 0; write_value = 0;
    write_restore_from_SPSR = 0; mode_read_en = 0; cpsr_read_en = 0;
    cpsr_write_en = 0; cpsr_write_value = 0; exc_en = 0; exc_mode = 0; exc_return = 0;
  endtask

  // Apply whatever requests are set up for exactly one rising edge.
  task automatic step();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic wr(input logic [3:0] r, input logic [31:0] v, input logic rs);
    write_en = 1; write_reg = r; write_value = v; write_restore_from_SPSR = rs;
    step();
  endtask

  task automatic cpsr_wr(input logic [31:0] v);
    cpsr_write_en = 1; cpsr_write_value = v;
    step();
  endtask

  task automatic rd(input logic [3:0] r, output logic [31:0] v);
    read_en = 1; read_reg = r;
    step();
    v = read_value;
  endtask

  task automatic cpsr_rd(output logic [31:0] v);
    cpsr_read_en = 1;
    step();
    v = cpsr_read_value;
  endtask

  task automatic mode_rd(output logic [31:0] v);
    mode_read_en = 1;
    step();
    v = mode_read_value;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    checks++;
    if (cpsr_read_value !== 32'h0) begin errors++; $display("FAIL reset_cpsr_out got %h want %h", cpsr_read_value, 32'h0); end
    checks++;
    if (read_value !== 32'h0) begin errors++; $display("FAIL reset_read_out got %h want %h", read_value, 32'h0); end
    cpsr_rd(v);
    checks++;
    if (v !== 32'h0000_00D3) begin errors++; $display("FAIL reset_cpsr got %h want %h", v, 32'hD3); end
    mode_rd(v);
    checks++;
    if (v !== 32'd4) begin errors++; $display("FAIL reset_mode got %h want %h", v, 32'd4); end
    rd(4'd3, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_r3 got %h want %h", v, 32'h0); end
  endtask

  task automatic test_banking();
    logic [31:0] v;
    wr(4'd13, 32'h1000, 0);
    cpsr_wr(32'h10);
    wr(4'd13, 32'h2000, 0);
    rd(4'd13, v);
    checks++;
    if (v !== 32'h2000) begin errors++; $display("FAIL usr_r13 got %h want %h", v, 32'h2000); end
    mode_rd(v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL usr_mode got %h want %h", v, 32'd0); end
    cpsr_wr(32'h13);
    rd(4'd13, v);
    checks++;
    if (v !== 32'h1000) begin errors++; $display("FAIL svc_r13 got %h want %h", v, 32'h1000); end
  endtask

  task automatic test_fiq_bank();
    logic [31:0] v;
    cpsr_wr(32'h11);
    wr(4'd8, 32'hAAAA, 0);
    mode_rd(v);
    checks++;
    if (v !== 32'd2) begin errors++; $display("FAIL fiq_mode got %h want %h", v, 32'd2); end
    rd(4'd13, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL fiq_r13 got %h want %h", v, 32'h0); end
    cpsr_wr(32'h10);
    rd(4'd8, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL usr_r8 got %h want %h", v, 32'h0); end
    cpsr_wr(32'h11);
    rd(4'd8, v);
    checks++;
    if (v !== 32'hAAAA) begin errors++; $display("FAIL fiq_r8 got %h want %h", v, 32'hAAAA); end
    // Undefined mode encoding decodes as USR
    cpsr_wr(32'h15);
    mode_rd(v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL bad_mode got %h want %h", v, 32'd0); end
  endtask

  task automatic test_exception_restore();
    logic [31:0] v;
    cpsr_wr(32'h6000_0010);
    exc_en = 1; exc_mode = 3'd3; exc_return = 32'h104;
    step();
    cpsr_rd(v);
    checks++;
    if (v !== 32'h6000_0092) begin errors++; $display("FAIL irq_cpsr got %h want %h", v, 32'h60000092); end
    mode_rd(v);
    checks++;
    if (v !== 32'd3) begin errors++; $display("FAIL irq_mode got %h want %h", v, 32'd3); end
    rd(4'd14, v);
    checks++;
    if (v !== 32'h104) begin errors++; $display("FAIL irq_r14 got %h want %h", v, 32'h104); end
    rd(4'd15, v);
    checks++;
    if (v !== 32'h18) begin errors++; $display("FAIL irq_r15 got %h want %h", v, 32'h18); end
    wr(4'd15, 32'h104, 1);
    cpsr_rd(v);
    checks++;
    if (v !== 32'h6000_0010) begin errors++; $display("FAIL restore_cpsr got %h want %h", v, 32'h60000010); end
    rd(4'd15, v);
    checks++;
    if (v !== 32'h104) begin errors++; $display("FAIL restore_r15 got %h want %h", v, 32'h104); end
    rd(4'd14, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL usr_r14 got %h want %h", v, 32'h0); end
    // Restore flag ignored in USR
    wr(4'd15, 32'h200, 1);
    cpsr_rd(v);
    checks++;
    if (v !== 32'h6000_0010) begin errors++; $display("FAIL usr_restore_cpsr got %h want %h", v, 32'h60000010); end
    rd(4'd15, v);
    checks++;
    if (v !== 32'h200) begin errors++; $display("FAIL usr_restore_r15 got %h want %h", v, 32'h200); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    wr(4'd2, 32'd5, 0);
    read_en = 1; read_reg = 4'd2;
    write_en = 1; write_reg = 4'd2; write_value = 32'd9;
    step();
    checks++;
    if (read_value !== 32'd5) begin errors++; $display("FAIL rdw_old got %h want %h", read_value, 32'd5); end
    // Output holds with no new request
    step();
    checks++;
    if (read_value !== 32'd5) begin errors++; $display("FAIL rd_hold got %h want %h", read_value, 32'd5); end
    rd(4'd2, v);
    checks++;
    if (v !== 32'd9) begin errors++; $display("FAIL rdw_new got %h want %h", v, 32'd9); end
  endtask

  task automatic test_priority();
    logic [31:0] v;
    // Currently USR, CPSR 0x60000010. Exception beats cpsr write and reg write.
    exc_en = 1; exc_mode = 3'd4; exc_return = 32'h55;
    cpsr_write_en = 1; cpsr_write_value = 32'h1F;
    write_en = 1; write_reg = 4'd0; write_value = 32'h77;
    step();
    cpsr_rd(v);
    checks++;
    if (v !== 32'h6000_0093) begin errors++; $display("FAIL exc_prio_cpsr got %h want %h", v, 32'h60000093); end
    rd(4'd0, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL exc_prio_r0 got %h want %h", v, 32'h0); end
    rd(4'd15, v);
    checks++;
    if (v !== 32'h8) begin errors++; $display("FAIL svc_vec got %h want %h", v, 32'h8); end
    rd(4'd14, v);
    checks++;
    if (v !== 32'h55) begin errors++; $display("FAIL svc_r14 got %h want %h", v, 32'h55); end
    rd(4'd13, v);
    checks++;
    if (v !== 32'h1000) begin errors++; $display("FAIL svc_r13_kept got %h want %h", v, 32'h1000); end
    // Invalid exc_mode ignored; coexisting cpsr write applies
    exc_en = 1; exc_mode = 3'd7; exc_return = 32'h99;
    cpsr_write_en = 1; cpsr_write_value = 32'h10;
    step();
    cpsr_rd(v);
    checks++;
    if (v !== 32'h10) begin errors++; $display("FAIL bad_exc_cpsr got %h want %h", v, 32'h10); end
    // FIQ entry sets F and I
    exc_en = 1; exc_mode = 3'd2; exc_return = 32'h300;
    step();
    cpsr_rd(v);
    checks++;
    if (v !== 32'hD1) begin errors++; $display("FAIL fiq_exc_cpsr got %h want %h", v, 32'hD1); end
    rd(4'd15, v);
    checks++;
    if (v !== 32'h1C) begin errors++; $display("FAIL fiq_vec got %h want %h", v, 32'h1C); end
    // Restore beats cpsr write
    write_en = 1; write_reg = 4'd15; write_value = 32'h400; write_restore_from_SPSR = 1;
    cpsr_write_en = 1; cpsr_write_value = 32'h1F;
    step();
    cpsr_rd(v);
    checks++;
    if (v !== 32'h10) begin errors++; $display("FAIL restore_prio_cpsr got %h want %h", v, 32'h10); end
    // Plain write + cpsr write: bank chosen by old mode (USR)
    write_en = 1; write_reg = 4'd13; write_value = 32'hBEEF;
    cpsr_write_en = 1; cpsr_write_value = 32'h13;
    step();
    rd(4'd13, v);
    checks++;
    if (v !== 32'h1000) begin errors++; $display("FAIL coexist_svc_r13 got %h want %h", v, 32'h1000); end
    cpsr_wr(32'h10);
    rd(4'd13, v);
    checks++;
    if (v !== 32'hBEEF) begin errors++; $display("FAIL coexist_usr_r13 got %h want %h", v, 32'hBEEF); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] v;
    write_en = 1; write_reg = 4'd2; write_value = 32'hDEAD;
    #2 rst_n = 0;
    #3 rst_n = 1;
    idle();
    @(posedge clk); #1;
    checks++;
    if (read_value !== 32'h0) begin errors++; $display("FAIL midrst_read_out got %h want %h", read_value, 32'h0); end
    cpsr_rd(v);
    checks++;
    if (v !== 32'hD3) begin errors++; $display("FAIL midrst_cpsr got %h want %h", v, 32'hD3); end
    rd(4'd2, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL midrst_r2 got %h want %h", v, 32'h0); end
  endtask

  initial begin
    idle();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk); #1;
    test_reset();
    test_banking();
    test_fiq_bank();
    test_exception_restore();
    test_back_to_back();
    test_priority();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
